key_edge_pio: RTL and testbench
===============================

KEY_EDGE_PIO -- requirements
Module: key_edge_pio

Interface
REQ-001 Parameter WIDTH, default 2, number of input bits (legal range 1..32).
REQ-002 Parameter SYNC_STAGES, default 2, number of synchroniser flops per bit (legal range 2..4).
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive stable clocks required before the debounced value changes (legal range >= 1).
REQ-004 Parameter EDGE_TYPE, default 1, edge-capture sense: 0 = rising, 1 = falling, 2 = any.
REQ-005 Parameter IDLE_HIGH, default 1; 1 = synchroniser and debounced registers reset to all-ones, 0 = reset to all-zeros.
REQ-006 Port clk, input, 1 bit, clock.
REQ-007 Port reset_n, input, 1 bit, reset; asynchronous, active-low.
REQ-008 Port address, input, 2 bits, Avalon-MM word address.
REQ-009 Port chipselect, input, 1 bit, slave select.
REQ-010 Port write_n, input, 1 bit, active-low write strobe.
REQ-011 Port writedata, input, 32 bits, write data.
REQ-012 Port readdata, output, 32 bits, registered read data.
REQ-013 Port in_port, input, WIDTH bits, asynchronous key inputs.
REQ-014 Port irq, output, 1 bit, level interrupt.

Function
REQ-015 Each in_port bit SHALL pass through SYNC_STAGES flops before any other use; the last stage is sync[i].
REQ-016 Each bit SHALL have a debounce counter of width clog2(DEBOUNCE_CYCLES+1) bits.
REQ-017 When sync[i] equals deb[i], the counter SHALL clear to 0.
REQ-018 When sync[i] differs from deb[i], the counter SHALL increment; on the clock where the count reaches DEBOUNCE_CYCLES-1, deb[i] SHALL load sync[i] and the counter SHALL clear.
REQ-019 A difference that persists for fewer than DEBOUNCE_CYCLES consecutive clocks SHALL leave deb[i] unchanged.
REQ-020 An edge event on bit i SHALL be asserted in the cycle deb[i] changes, qualified by EDGE_TYPE: 0 → 0-to-1 transitions only; 1 → 1-to-0 transitions only; 2 → either direction.
REQ-021 An edge event SHALL set edge_cap[i], which is sticky.
REQ-022 Register map, reads:
- address 0 → deb, zero-extended to 32 bits.
- address 1 → 0.
- address 2 → irq_mask.
- address 3 → edge_cap.
REQ-023 Register map, writes: a write is chipselect=1 and write_n=0.
- address 2 → irq_mask loads writedata[WIDTH-1:0].
- address 3 → each edge_cap bit whose writedata bit is 1 is cleared (write-1-to-clear).
- writes to addresses 0 and 1 are ignored.
REQ-024 When a new edge event and a W1C write hit the same edge_cap bit in the same clock, the set SHALL win and the bit SHALL remain 1.
REQ-025 readdata SHALL register the address-selected value on every clock, giving read latency 1; reads have no side effects.
REQ-026 readdata bits [31:WIDTH] SHALL always read 0.
REQ-027 irq SHALL equal the OR-reduction of (edge_cap AND irq_mask), driven combinationally from registers.
REQ-028 irq SHALL deassert the cycle after the last contributing bit is cleared or masked.
REQ-029 Reset value of the IDLE_HIGH level SHALL ensure that no edge event is generated by reset release alone while in_port sits at its idle level.

Reset
REQ-030 While reset_n=0, asynchronously:
- readdata, irq_mask, edge_cap and all counters SHALL be 0.
- sync stages and deb SHALL be {WIDTH{IDLE_HIGH}}.
- irq SHALL be 0.
REQ-031 Reset asserted mid-debounce SHALL discard the partial count; any in-flight edge_cap set SHALL not survive reset.

Verification
REQ-032 Reset with in_port=2'b11 (defaults), then read addresses 0/2/3 → 0x3, 0x0, 0x0; irq=0 for 100 clocks.
REQ-033 Pulse in_port[0] low for 10 clocks, then restore high → deb stays 2'b11; edge_cap=0.
REQ-034 Hold in_port[0] low for 40 clocks → deb=2'b10 exactly DEBOUNCE_CYCLES+SYNC_STAGES clocks after the input change; edge_cap=0x1; irq=0 while mask=0; write 0x1 to address 2 → irq=1 the next cycle.
REQ-035 Write 0x1 to address 3 → edge_cap=0, irq=0 the next cycle; a write of 0x2 instead leaves edge_cap=0x1.
REQ-036 Time a W1C write of 0x1 to address 3 to coincide with deb[0] falling → edge_cap[0]=1 afterwards.
REQ-037 Use EDGE_TYPE=2, WIDTH=8; toggle in_port[7] low then high with stable periods → edge_cap[7] sets on both transitions; address 0 read returns bits [31:8]=0.

Source files
------------

// File: rtl/key_edge_pio.sv
// Debounced key input PIO with Avalon-MM slave: synchroniser, per-bit debounce
// counter, sticky edge capture with W1C clear, and maskable level interrupt.
module key_edge_pio #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_HIGH       = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             IDLE_BIT = (IDLE_HIGH != 32'sd0);
  localparam logic [WIDTH-1:0] IDLE_VAL = {WIDTH{IDLE_BIT}};
  localparam logic [1:0]       EDGE_SEL = 2'(EDGE_TYPE);

  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] sync_last_s;
  logic [WIDTH-1:0] deb_r;
  logic [WIDTH-1:0] load_s;
  logic [WIDTH-1:0] rise_s;
  logic [WIDTH-1:0] fall_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] edge_cap_r;
  logic [WIDTH-1:0] irq_mask_r;
  logic [WIDTH-1:0] clr_s;
  logic             wr_s;
  logic             wr_mask_s;
  logic             wr_edge_s;
  logic [31:0]      rd_mux_s;
  logic [31:0]      readdata_r;

  // Synchroniser chain; reset to the idle level so release does not look like a key press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= IDLE_VAL;
      end
    end else begin
      sync_r[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  assign sync_last_s = sync_r[SYNC_STAGES-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_W-1:0] cnt_r;
    logic             diff_s;

    assign diff_s    = (sync_last_s[i] != deb_r[i]);
    assign load_s[i] = diff_s && (cnt_r == CNT_LAST);

    // Count consecutive clocks of disagreement; any agreement restarts the window.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_r <= '0;
      end else if (!diff_s) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Debounced value takes the synchronised level only on a completed window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_r <= IDLE_VAL;
    end else begin
      deb_r <= (deb_r & ~load_s) | (sync_last_s & load_s);
    end
  end

  assign rise_s = load_s & sync_last_s;
  assign fall_s = load_s & ~sync_last_s;

  // Edge qualification by configured sense.
  always_comb begin
    edge_s = {WIDTH{1'b0}};
    case (EDGE_SEL)
      2'd0:    edge_s = rise_s;
      2'd1:    edge_s = fall_s;
      2'd2:    edge_s = rise_s | fall_s;
      default: edge_s = fall_s;
    endcase
  end

  assign wr_s      = chipselect && !write_n;
  assign wr_mask_s = wr_s && (address == 2'd2);
  assign wr_edge_s = wr_s && (address == 2'd3);

  // W1C clear vector; zero unless this clock carries an edge-capture write.
  always_comb begin
    if (wr_edge_s) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
  end

  // Interrupt mask and sticky edge capture; a new edge beats a same-clock clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_r <= {WIDTH{1'b0}};
      edge_cap_r <= {WIDTH{1'b0}};
    end else begin
      if (wr_mask_s) begin
        irq_mask_r <= writedata[WIDTH-1:0];
      end else begin
        irq_mask_r <= irq_mask_r;
      end
      edge_cap_r <= (edge_cap_r & ~clr_s) | edge_s;
    end
  end

  // Read mux; unused upper bits stay zero.
  always_comb begin
    rd_mux_s = 32'd0;
    case (address)
      2'd0:    rd_mux_s[WIDTH-1:0] = deb_r;
      2'd1:    rd_mux_s = 32'd0;
      2'd2:    rd_mux_s[WIDTH-1:0] = irq_mask_r;
      2'd3:    rd_mux_s[WIDTH-1:0] = edge_cap_r;
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Read data is registered every clock regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'd0;
    end else begin
      readdata_r <= rd_mux_s;
    end
  end

  assign readdata = readdata_r;
  assign irq      = |(edge_cap_r & irq_mask_r);

  if (WIDTH < 32) begin : g_unused
    logic unused_s;
    assign unused_s = ^writedata[31:WIDTH];
  end

endmodule

// File: tb/tb_key_edge_pio.sv
// Directed bench for key_edge_pio: default instance (2 bits, falling edges)
// and an 8-bit any-edge instance sharing the bus.
module tb_key_edge_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs_a;
  logic        cs_b;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in_a;
  logic [7:0]  in_b;
  logic [31:0] rd_a;
  logic [31:0] rd_b;
  logic        irq_a;
  logic        irq_b;

  int n_cmp = 0;
  int n_err = 0;

  key_edge_pio dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .irq(irq_a)
  );

  key_edge_pio #(.WIDTH(8), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .irq(irq_b)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    tick(1);
  endtask

  task automatic wr(input bit sel_b, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_a      = !sel_b;
    cs_b      = sel_b;
    tick(1);
    write_n   = 1'b1;
    cs_a      = 1'b0;
    cs_b      = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; in_a = 2'b11; in_b = 8'hFF; address = 2'd0;
    cs_a = 1'b0; cs_b = 1'b0; write_n = 1'b1; writedata = 32'd0;
    #12;
    chk("rst_rdata_a", rd_a, 32'd0);
    chk("rst_rdata_b", rd_b, 32'd0);
    chk("rst_irq_a", {31'd0, irq_a}, 32'd0);
    reset_n = 1'b1;

    // idle after reset
    rd(2'd0); chk("idle_deb", rd_a, 32'h3);
    rd(2'd2); chk("idle_mask", rd_a, 32'h0);
    rd(2'd3); chk("idle_ecap", rd_a, 32'h0);
    for (int c = 0; c < 100; c++) begin
      tick(1);
      chk("idle_irq", {31'd0, irq_a}, 32'd0);
    end

    // 10-clock glitch is rejected
    address = 2'd0; tick(2);
    in_a = 2'b10; tick(10); in_a = 2'b11;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      chk("glitch_deb", rd_a, 32'h3);
    end
    rd(2'd3); chk("glitch_ecap", rd_a, 32'h0);

    // sustained press: deb changes exactly 18 clocks after the input
    address = 2'd0; tick(2);
    in_a = 2'b10;
    tick(18); chk("press_deb_pre", rd_a, 32'h3);
    tick(1);  chk("press_deb_post", rd_a, 32'h2);
    tick(21);
    rd(2'd3); chk("press_ecap", rd_a, 32'h1);
    chk("press_irq_masked", {31'd0, irq_a}, 32'd0);
    wr(1'b0, 2'd2, 32'h1); chk("mask_irq_on", {31'd0, irq_a}, 32'd1);
    rd(2'd2); chk("mask_read", rd_a, 32'h1);

    // W1C on wrong bit, then right bit
    wr(1'b0, 2'd3, 32'h2); chk("w1c_other_irq", {31'd0, irq_a}, 32'd1);
    rd(2'd3); chk("w1c_other_ecap", rd_a, 32'h1);
    wr(1'b0, 2'd3, 32'h1); chk("w1c_irq_off", {31'd0, irq_a}, 32'd0);
    rd(2'd3); chk("w1c_ecap", rd_a, 32'h0);

    // writes to addresses 0 and 1 are ignored
    wr(1'b0, 2'd0, 32'h0); rd(2'd0); chk("wr0_ignored", rd_a, 32'h2);
    wr(1'b0, 2'd1, 32'hFFFFFFFF); rd(2'd1); chk("addr1_zero", rd_a, 32'h0);
    rd(2'd2); chk("mask_kept", rd_a, 32'h1);

    // release: rising edge not captured in falling mode
    in_a = 2'b11; tick(25);
    rd(2'd0); chk("release_deb", rd_a, 32'h3);
    rd(2'd3); chk("release_ecap", rd_a, 32'h0);
    chk("release_irq", {31'd0, irq_a}, 32'd0);

    // W1C lands on the same clock as deb[0] falls: set wins
    in_a = 2'b10; tick(17);
    wr(1'b0, 2'd3, 32'h1);
    chk("collide_irq", {31'd0, irq_a}, 32'd1);
    rd(2'd3); chk("collide_ecap", rd_a, 32'h1);
    rd(2'd0); chk("collide_deb", rd_a, 32'h2);

    // masking drops irq next cycle while capture stays pending
    wr(1'b0, 2'd2, 32'h0); chk("unmask_irq_off", {31'd0, irq_a}, 32'd0);
    rd(2'd3); chk("unmask_ecap", rd_a, 32'h1);
    wr(1'b0, 2'd2, 32'h1); chk("remask_irq_on", {31'd0, irq_a}, 32'd1);
    wr(1'b0, 2'd3, 32'h1); chk("clear_irq_off", {31'd0, irq_a}, 32'd0);

    // reset during a debounce window discards the partial count
    in_a = 2'b11; tick(25);
    in_a = 2'b10; tick(10);
    reset_n = 1'b0; #1;
    chk("midrst_rdata", rd_a, 32'd0);
    chk("midrst_irq", {31'd0, irq_a}, 32'd0);
    address = 2'd0;
    tick(2);
    reset_n = 1'b1;
    tick(18); chk("midrst_deb_pre", rd_a, 32'h3);
    tick(1);  chk("midrst_deb_post", rd_a, 32'h2);
    rd(2'd2); chk("midrst_mask", rd_a, 32'h0);
    rd(2'd3); chk("midrst_ecap", rd_a, 32'h1);
    chk("midrst_irq_after", {31'd0, irq_a}, 32'd0);

    // 8-bit any-edge instance: both directions captured on bit 7
    in_b = 8'h7F; tick(25);
    rd(2'd3); chk("b_fall_ecap", rd_b, 32'h80);
    wr(1'b1, 2'd3, 32'h80);
    rd(2'd3); chk("b_w1c_ecap", rd_b, 32'h0);
    in_b = 8'hFF; tick(25);
    rd(2'd3); chk("b_rise_ecap", rd_b, 32'h80);
    rd(2'd0); chk("b_deb_zero_ext", rd_b, 32'h000000FF);
    rd(2'd1); chk("b_addr1", rd_b, 32'h0);
    chk("b_irq_masked", {31'd0, irq_b}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
